// File: rtl/pc_pkg.sv
// ============================================================================
// Module : pc_pkg
// Brief  : Shared types and constants for the fetch-stage PC sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pc_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int INSTR_BYTES = 4;

    typedef logic [DATA_WIDTH-1:0] addr_t;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        WAIT_MEM = 2'd2
    } pc_state_t;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module : sat_counter
// Brief  : Up-counter that sticks at all-ones; generic performance counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic                 clr_i,
    output logic [CNT_WIDTH-1:0] count_o
);

    logic [CNT_WIDTH-1:0] r_count;

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clr_i) begin
            r_count <= '0;
        end else if (en_i && (r_count != {CNT_WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count_o = r_count;

endmodule

`default_nettype wire

// File: rtl/pc_ctrl.sv
// ============================================================================
// Module : pc_ctrl
// Brief  : Fetch-stage sequencer: next-PC arbitration, F/D/E stall and flush
//          generation, and a saturating stall-cycle counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_ctrl
    import pc_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int INSTR_BYTES = 4,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] PCF_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_target_i,
    input  logic                  load_use_stall_i,
    input  logic                  imem_ready_i,
    output logic                  imem_req_o,
    output logic [DATA_WIDTH-1:0] PCNext_o,
    output logic                  pc_en_o,
    output logic                  stallD_o,
    output logic                  flushD_o,
    output logic                  flushE_o,
    output logic [CNT_WIDTH-1:0]  stall_cnt_o
);

    pc_state_t             r_state;
    pc_state_t             w_state_nxt;
    logic                  r_pend_valid;
    logic                  w_pend_valid_nxt;
    logic [DATA_WIDTH-1:0] r_pend_target;
    logic [DATA_WIDTH-1:0] w_pend_target_nxt;
    logic [DATA_WIDTH-1:0] w_pc_seq;
    logic                  w_cnt_en;

    // Sequential increment wraps naturally at 2^DATA_WIDTH.
    assign w_pc_seq = PCF_i + DATA_WIDTH'(INSTR_BYTES);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state       <= BOOT;
            r_pend_valid  <= 1'b0;
            r_pend_target <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_pend_valid  <= w_pend_valid_nxt;
            r_pend_target <= w_pend_target_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_pend_valid_nxt  = r_pend_valid;
        w_pend_target_nxt = r_pend_target;
        imem_req_o        = 1'b0;
        PCNext_o          = w_pc_seq;
        pc_en_o           = 1'b0;
        stallD_o          = 1'b0;
        flushD_o          = 1'b0;
        flushE_o          = 1'b0;

        case (r_state)
            BOOT: begin
                flushD_o    = 1'b1;
                flushE_o    = 1'b1;
                w_state_nxt = RUN;
            end

            RUN: begin
                imem_req_o = 1'b1;
                if (redirect_i) begin
                    PCNext_o = redirect_target_i;
                    flushD_o = 1'b1;
                    flushE_o = 1'b1;
                    if (imem_ready_i) begin
                        pc_en_o = 1'b1;
                    end else begin
                        w_pend_valid_nxt  = 1'b1;
                        w_pend_target_nxt = redirect_target_i;
                        w_state_nxt       = WAIT_MEM;
                    end
                end else if (load_use_stall_i) begin
                    stallD_o = 1'b1;
                    flushE_o = 1'b1;
                end else if (!imem_ready_i) begin
                    flushD_o    = 1'b1;
                    w_state_nxt = WAIT_MEM;
                end else begin
                    pc_en_o = 1'b1;
                end
            end

            WAIT_MEM: begin
                imem_req_o = 1'b1;
                if (redirect_i) begin
                    flushD_o = 1'b1;
                    flushE_o = 1'b1;
                end else if (load_use_stall_i) begin
                    stallD_o = 1'b1;
                    flushE_o = 1'b1;
                end else begin
                    flushD_o = 1'b1;
                end

                if (imem_ready_i) begin
                    w_state_nxt      = RUN;
                    w_pend_valid_nxt = 1'b0;
                    if (redirect_i) begin
                        PCNext_o = redirect_target_i;
                        pc_en_o  = 1'b1;
                    end else if (r_pend_valid) begin
                        // Fetched word is wrong-path: replace any hold with a flush.
                        PCNext_o = r_pend_target;
                        pc_en_o  = 1'b1;
                        stallD_o = 1'b0;
                        flushD_o = 1'b1;
                    end else begin
                        // A load-use hold keeps the PC frozen; RUN refetches it.
                        pc_en_o = !load_use_stall_i;
                    end
                end else if (redirect_i) begin
                    w_pend_valid_nxt  = 1'b1;
                    w_pend_target_nxt = redirect_target_i;
                end
            end

            default: begin
                w_state_nxt = BOOT;
            end
        endcase
    end

    assign w_cnt_en = (r_state != BOOT) && !pc_en_o;

    sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_stall_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .en_i    (w_cnt_en),
        .clr_i   (1'b0),
        .count_o (stall_cnt_o)
    );

endmodule

`default_nettype wire
